sodor_state_init_seq: RTL and testbench
=======================================

Name: sodor_state_init_seq

Overview:
Sequencer that brings the sodor5 verification harness into a known architectural state before execution.
- Writes identical pseudo-random values into the register files of both the reference model and the core, through a shared write port that fans out to both.
- Writes a deterministic pattern into both data memories.
- Holds the core in reset until initialisation completes, then releases it.
- Replaces hierarchical backdoor initialisation with a synthesizable, cycle-accurate write sequence.

Parameters:
- NUM_REGS, 32, number of architectural registers written (addresses 0..NUM_REGS-1).
- WORD_SIZE, 32, data width; LFSR width equals WORD_SIZE.
- MEM_WORDS, 16, data-memory words initialised (addresses 0..MEM_WORDS-1).
- MEM_STEP, 32'h11111111, memory word k receives k*MEM_STEP mod 2^WORD_SIZE.
- ZERO_X0, 1, when 1, register 0 is written with 0.
- RELEASE_CYCLES, 2, cycles core_reset stays high after the last memory write.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins (re)initialisation.
- seed_in  in  WORD_SIZE  LFSR seed, sampled when start is accepted.
- wr_ready  in  1  sink accepts the current rf/mem write this cycle.
- rf_wen  out  1  register-file write enable (fans out to model and core).
- rf_waddr  out  $clog2(NUM_REGS)  register address.
- rf_wdata  out  WORD_SIZE  register data.
- mem_wen  out  1  data-memory write enable (fans out to both memories).
- mem_waddr  out  $clog2(MEM_WORDS)  word address.
- mem_wdata  out  WORD_SIZE  word data.
- core_reset  out  1  reset to core and model; high until initialisation completes.
- busy  out  1  high in REGS, MEM and RELEASE.
- done  out  1  high in RUN.

Behaviour:
- Clock `clk`; reset `reset`, synchronous, active-high.
- All outputs are registered.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, mem_wen=0, mem_waddr=0, mem_wdata=0, core_reset=1, busy=0, done=0, state=IDLE, lfsr=1.
- FSM states: IDLE, REGS, MEM, RELEASE, RUN.
  - IDLE: core_reset=1. start -> REGS.
  - REGS: rf_wen=1 at address k, k = 0..NUM_REGS-1.
  - MEM: mem_wen=1 at address k, k = 0..MEM_WORDS-1.
  - RELEASE: counter runs RELEASE_CYCLES cycles with core_reset=1, then -> RUN.
  - RUN: core_reset=0, done=1.
- start in REGS, MEM or RELEASE: ignored.
- start in RUN: -> REGS; core_reset=1 and done=0 from the next cycle.
- Seed: on accepted start, lfsr <= seed_in; seed_in==0 is replaced by 1 to avoid LFSR lock-up.
- LFSR: 32-bit Galois, right-shift, TAPS=32'h80200003.
  - next = (s>>1) ^ (s[0] ? TAPS : 0).
  - Advances after every accepted register write, including k=0.
  - Register data = lfsr before the advance, except k=0 with ZERO_X0=1, which writes 0.
- Write handshake: a write is accepted when wen && wr_ready.
  - While wen=1 and wr_ready=0, the address, data and enable of that write are held stable.
  - Address and LFSR do not advance until acceptance.
- Only one of rf_wen and mem_wen is ever high in a cycle.
- Timing with wr_ready=1 throughout and start at cycle t:
  - rf writes occupy cycles t+1..t+NUM_REGS.
  - mem writes occupy the next MEM_WORDS cycles.
  - RELEASE occupies the next RELEASE_CYCLES cycles.
  - With defaults: core_reset falls and done rises at t+51.
- Address counters wrap exactly at NUM_REGS-1 and MEM_WORDS-1 into the next state; there are no extra writes.
- Mem data multiply is done mod 2^WORD_SIZE.
- reset mid-operation: the next cycle returns to reset values (IDLE, core_reset=1). A partially written state is not resumed.
- reset and start in the same cycle: reset wins.

Decomposition:
- Package sodor_init_pkg: state enum (IDLE, REGS, MEM, RELEASE, RUN), LFSR_TAPS=32'h80200003, NUM_REGS/WORD_SIZE/MEM_WORDS default constants, and a next-LFSR function.
- One sub-module, lfsr32_galois, with ports clk, reset, load, load_val, step, and output state.

Test Plan:
- Reset, then start with seed_in=1 and wr_ready=1 -> writes r0=0, r1=32'h80200003, r2=32'hC0300002. 32 rf writes followed by 16 mem writes, mem[5]=32'h55555555 and mem[15]=32'hFFFFFFFF. core_reset falls exactly 51 cycles after start.
- seed_in=0 -> identical sequence to seed_in=1 (r1=32'h80200003).
- wr_ready low for 3 cycles during the write to r7 -> rf_waddr=7 and rf_wdata held unchanged for 4 cycles. r8 value is the same as in the no-stall run; total latency is 54.
- reset asserted during MEM at address 9 -> next cycle IDLE, mem_wen=0, core_reset=1. A new start gives a full run with r1=step(seed_in).
- start pulsed in REGS at address 10 -> ignored, and the sequence is cycle-identical to the baseline. start in RUN -> core_reset=1 the next cycle and rf writes restart at address 0.
- Every cycle (assertion): rf_wen and mem_wen are never both high, and busy==(state in REGS/MEM/RELEASE).

Source files
------------

// File: rtl/sodor_init_pkg.sv
// Shared types and helpers for the sodor5 harness state initialisation sequencer.
// Holds the FSM state encoding, default sizes and the Galois LFSR step function.
package sodor_init_pkg;

    localparam int NUM_REGS_DEF  = 32;
    localparam int WORD_SIZE_DEF = 32;
    localparam int MEM_WORDS_DEF = 16;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        IDLE,
        REGS,
        MEM,
        RELEASE,
        RUN
    } init_state_e;

    // Right-shifting Galois step; the taps fold back in when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/sodor_state_init_seq_lfsr32_galois.sv
// 32-bit Galois LFSR with synchronous load; load takes priority over step.
// Resets to 1 so the register never sits in the all-zero lock-up state.
module lfsr32_galois
    import sodor_init_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 32'd1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sodor_state_init_seq.sv
// Initialisation sequencer: writes LFSR data to both register files, a ramp to both
// data memories, then releases the core from reset. All outputs come straight from flops.
module sodor_state_init_seq
    import sodor_init_pkg::*;
#(
    parameter int                   NUM_REGS       = NUM_REGS_DEF,
    parameter int                   WORD_SIZE      = WORD_SIZE_DEF,
    parameter int                   MEM_WORDS      = MEM_WORDS_DEF,
    parameter logic [WORD_SIZE-1:0] MEM_STEP       = 32'h11111111,
    parameter bit                   ZERO_X0        = 1'b1,
    parameter int                   RELEASE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WORD_SIZE-1:0]         seed_in,
    input  logic                         wr_ready,
    output logic                         rf_wen,
    output logic [$clog2(NUM_REGS)-1:0]  rf_waddr,
    output logic [WORD_SIZE-1:0]         rf_wdata,
    output logic                         mem_wen,
    output logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    output logic                         core_reset,
    output logic                         busy,
    output logic                         done
);

    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    init_state_e          state_q, state_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [RA_W-1:0]      rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic                 mem_wen_q, mem_wen_d;
    logic [MA_W-1:0]      mem_waddr_q, mem_waddr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 core_reset_q, core_reset_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [REL_W-1:0]     rel_cnt_q, rel_cnt_d;

    logic                 lfsr_load;
    logic                 lfsr_step;
    logic [31:0]          lfsr_q;
    logic [31:0]          seed_eff;
    logic [MA_W-1:0]      mem_addr_inc;

    assign seed_eff     = (seed_in == '0) ? 32'd1 : 32'(seed_in);
    assign mem_addr_inc = mem_waddr_q + 1'b1;

    lfsr32_galois u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (seed_eff),
        .step     (lfsr_step),
        .state    (lfsr_q)
    );

    // Everything holds by default, which also keeps a stalled write stable.
    always_comb begin
        state_d      = state_q;
        rf_wen_d     = rf_wen_q;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        mem_wen_d    = mem_wen_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        rel_cnt_d    = rel_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;

        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d     = REGS;
                    lfsr_load   = 1'b1;
                    rf_wen_d    = 1'b1;
                    rf_waddr_d  = '0;
                    rf_wdata_d  = ZERO_X0 ? '0 : WORD_SIZE'(seed_eff);
                    mem_wen_d   = 1'b0;
                    mem_waddr_d = '0;
                    mem_wdata_d = '0;
                end
            end
            REGS: begin
                // Data for write k+1 is the LFSR value after the step that write k triggers.
                if (rf_wen_q && wr_ready) begin
                    lfsr_step = 1'b1;
                    if (rf_waddr_q == RA_W'(NUM_REGS - 1)) begin
                        state_d     = MEM;
                        rf_wen_d    = 1'b0;
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = '0;
                        mem_wdata_d = '0;
                    end else begin
                        rf_waddr_d = rf_waddr_q + 1'b1;
                        rf_wdata_d = WORD_SIZE'(lfsr_next(lfsr_q));
                    end
                end
            end
            MEM: begin
                if (mem_wen_q && wr_ready) begin
                    if (mem_waddr_q == MA_W'(MEM_WORDS - 1)) begin
                        state_d   = RELEASE;
                        mem_wen_d = 1'b0;
                        rel_cnt_d = '0;
                    end else begin
                        mem_waddr_d = mem_addr_inc;
                        mem_wdata_d = WORD_SIZE'(mem_addr_inc) * MEM_STEP;
                    end
                end
            end
            RELEASE: begin
                if (rel_cnt_q == REL_W'(RELEASE_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d == REGS) || (state_d == MEM) || (state_d == RELEASE);
        done_d       = (state_d == RUN);
        core_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rel_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign mem_wen    = mem_wen_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sodor_state_init_seq.sv
// Directed self-checking bench for sodor_state_init_seq: baseline, zero seed, stall,
// ignored start, restart from RUN and mid-MEM reset, with per-cycle invariant checks.
module tb_sodor_state_init_seq;
    import sodor_init_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed_in;
    logic        wr_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_wen;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    logic [31:0] rf_seen  [32];
    logic [31:0] mem_seen [16];
    int          rf_count;
    int          mem_count;

    sodor_state_init_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_in    (seed_in),
        .wr_ready   (wr_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] tbStep(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    // Outputs change only on posedge, so negedge sampling sees settled values.
    always @(negedge clk) begin
        if (mon_on) begin
            checkOutput("wen_exclusive", 64'(rf_wen && mem_wen), 64'd0);
            checkOutput("busy_vs_state", 64'(busy),
                        64'((dut.state_q == REGS) || (dut.state_q == MEM) || (dut.state_q == RELEASE)));
            checkOutput("done_vs_state", 64'(done), 64'(dut.state_q == RUN));
        end
    end

    task automatic verifyImage(input logic [31:0] seed);
        logic [31:0] s;
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("rf_img[%0d]", k), 64'(rf_seen[k]), 64'((k == 0) ? 32'd0 : s));
            s = tbStep(s);
        end
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("mem_img[%0d]", k), 64'(mem_seen[k]), 64'(32'(k) * 32'h11111111));
        end
    endtask

    // Starts a run from the current negedge and follows it until done or a cycle budget.
    task automatic applyStimulus(input logic [31:0] seed, input int stall_addr, input int pulse_addr,
                                 output int lat, output logic [63:0] sig);
        int          hold_cycles = 0;
        bit          pulsed      = 1'b0;
        bit          prev_stall  = 1'b0;
        logic [4:0]  prev_addr   = '0;
        logic [31:0] prev_data   = '0;
        rf_count  = 0;
        mem_count = 0;
        sig       = 64'd0;
        lat       = 0;
        seed_in   = seed;
        start     = 1'b1;
        wr_ready  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            sig = (sig * 64'd1099511628211) ^ {rf_wdata, mem_wdata};
            sig = (sig * 64'd1099511628211) ^ 64'({rf_wen, rf_waddr, mem_wen, mem_waddr, core_reset, busy, done});
            if (lat == 1) begin
                checkOutput("first_rf_wen", 64'(rf_wen), 64'd1);
                checkOutput("first_rf_addr", 64'(rf_waddr), 64'd0);
                checkOutput("first_rf_data", 64'(rf_wdata), 64'd0);
                checkOutput("first_core_reset", 64'(core_reset), 64'd1);
                checkOutput("first_done", 64'(done), 64'd0);
            end
            if (prev_stall) begin
                checkOutput("hold_wen", 64'(rf_wen), 64'd1);
                checkOutput("hold_addr", 64'(rf_waddr), 64'(prev_addr));
                checkOutput("hold_data", 64'(rf_wdata), 64'(prev_data));
            end
            if (done) break;
            if (rf_wen && int'(rf_waddr) == stall_addr) begin
                hold_cycles++;
                wr_ready = (hold_cycles > 3);
            end else begin
                wr_ready = 1'b1;
            end
            if (!pulsed && rf_wen && int'(rf_waddr) == pulse_addr) begin
                start   = 1'b1;
                seed_in = ~seed;
                pulsed  = 1'b1;
            end
            prev_stall = rf_wen && !wr_ready;
            prev_addr  = rf_waddr;
            prev_data  = rf_wdata;
            if (rf_wen && wr_ready) begin
                checkOutput("rf_addr_order", 64'(rf_waddr), 64'(rf_count));
                rf_seen[rf_waddr] = rf_wdata;
                rf_count++;
            end
            if (mem_wen && wr_ready) begin
                checkOutput("mem_addr_order", 64'(mem_waddr), 64'(mem_count));
                mem_seen[mem_waddr] = mem_wdata;
                mem_count++;
            end
        end
        wr_ready = 1'b1;
        checkOutput("run_completes", 64'(done), 64'd1);
        checkOutput("rf_write_count", 64'(rf_count), 64'd32);
        checkOutput("mem_write_count", 64'(mem_count), 64'd16);
        checkOutput("release_core_reset", 64'(core_reset), 64'd0);
        if (stall_addr >= 0) checkOutput("stall_hold_cycles", 64'(hold_cycles), 64'd4);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] sig_base, sig;
        logic [31:0] r8_base;
        bit          found;

        reset    = 1'b1;
        start    = 1'b0;
        seed_in  = 32'd0;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_rf_wen", 64'(rf_wen), 64'd0);
        checkOutput("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        checkOutput("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        checkOutput("rst_mem_wen", 64'(mem_wen), 64'd0);
        checkOutput("rst_mem_waddr", 64'(mem_waddr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        reset  = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_core_reset", 64'(core_reset), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] baseline run, seed 1");
        applyStimulus(32'd1, -1, -1, lat, sig_base);
        checkOutput("base_latency", 64'(lat), 64'd51);
        checkOutput("base_r0", 64'(rf_seen[0]), 64'h0);
        checkOutput("base_r1", 64'(rf_seen[1]), 64'h80200003);
        checkOutput("base_r2", 64'(rf_seen[2]), 64'hC0300002);
        checkOutput("base_mem5", 64'(mem_seen[5]), 64'h55555555);
        checkOutput("base_mem15", 64'(mem_seen[15]), 64'hFFFFFFFF);
        verifyImage(32'd1);
        r8_base = rf_seen[8];
        @(negedge clk);
        checkOutput("run_done_holds", 64'(done), 64'd1);
        checkOutput("run_core_reset_low", 64'(core_reset), 64'd0);

        $display("[TB] restart from RUN with seed 0");
        applyStimulus(32'd0, -1, -1, lat, sig);
        checkOutput("zero_latency", 64'(lat), 64'd51);
        checkOutput("zero_r1", 64'(rf_seen[1]), 64'h80200003);
        checkOutput("zero_trace_same", sig, sig_base);
        verifyImage(32'd0);

        $display("[TB] stall on r7");
        applyStimulus(32'd1, 7, -1, lat, sig);
        checkOutput("stall_latency", 64'(lat), 64'd54);
        checkOutput("stall_r8", 64'(rf_seen[8]), 64'(r8_base));
        verifyImage(32'd1);

        $display("[TB] start pulse during REGS");
        applyStimulus(32'd1, -1, 10, lat, sig);
        checkOutput("pulse_latency", 64'(lat), 64'd51);
        checkOutput("pulse_trace_same", sig, sig_base);

        $display("[TB] reset during MEM");
        seed_in = 32'd1;
        start   = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_wen && mem_waddr == 4'd9) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_mem9", 64'(found), 64'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mem_wen", 64'(mem_wen), 64'd0);
        checkOutput("midrst_mem_waddr", 64'(mem_waddr), 64'd0);
        checkOutput("midrst_rf_wen", 64'(rf_wen), 64'd0);
        checkOutput("midrst_core_reset", 64'(core_reset), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_busy", 64'(busy), 64'd0);
        checkOutput("after_rst_done", 64'(done), 64'd0);

        applyStimulus(32'h12345678, -1, -1, lat, sig);
        checkOutput("rerun_latency", 64'(lat), 64'd51);
        checkOutput("rerun_r1", 64'(rf_seen[1]), 64'(tbStep(32'h12345678)));
        verifyImage(32'h12345678);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
